// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin share of one APB master port among N_REQ requesters (optional watchdog: APB_ARB_TIMEOUT_EN).
// Latency: request -> m_psel +1, m_penable +2, s_pready +3 with a zero-wait slave; 4 cycles minimum per transfer.
// Backpressure: non-granted requesters hold their request; a slow slave stretches ACCESS (bounded only with the watchdog).
module apb_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [N_REQ-1:0]            s_psel,
  input  logic [N_REQ-1:0]            s_penable,
  input  logic [N_REQ-1:0]            s_pwrite,
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_paddr,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_pwdata,
  output logic [DATA_WIDTH-1:0]       s_prdata,
  output logic [N_REQ-1:0]            s_pready,
  output logic [N_REQ-1:0]            s_pslverr,
  output logic                        m_psel,
  output logic                        m_penable,
  output logic                        m_pwrite,
  output logic [ADDR_WIDTH-1:0]       m_paddr,
  output logic [DATA_WIDTH-1:0]       m_pwdata,
  input  logic [DATA_WIDTH-1:0]       m_prdata,
  input  logic                        m_pready,
  input  logic                        m_pslverr,
  output logic [N_REQ-1:0]            grant
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = IW + 1;

  logic [1:0]            state_q,      state_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [N_REQ-1:0]      grant_q,      grant_d;
  logic                  m_psel_q,     m_psel_d;
  logic                  m_penable_q,  m_penable_d;
  logic                  m_pwrite_q,   m_pwrite_d;
  logic [ADDR_WIDTH-1:0] m_paddr_q,    m_paddr_d;
  logic [DATA_WIDTH-1:0] m_pwdata_q,   m_pwdata_d;
  logic [DATA_WIDTH-1:0] s_prdata_q,   s_prdata_d;
  logic [N_REQ-1:0]      s_pready_q,   s_pready_d;
  logic [N_REQ-1:0]      s_pslverr_q,  s_pslverr_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            tmo_cnt_q,    tmo_cnt_d;
`endif

  logic [CW-1:0]         cand;
  logic [IW-1:0]         pick_idx;
  logic                  pick_vld;
  logic [N_REQ-1:0]      pick_oh;

  logic                  unused_inputs;
  assign unused_inputs = ^{s_penable, 32'(TIMEOUT_CYCLES)};

  // Search starts one past the previous owner, so a back-to-back requester yields.
  always_comb begin
    cand     = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_grant_q} + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!pick_vld && s_psel[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    m_psel_d     = m_psel_q;
    m_penable_d  = m_penable_q;
    m_pwrite_d   = m_pwrite_q;
    m_paddr_d    = m_paddr_q;
    m_pwdata_d   = m_pwdata_q;
    s_prdata_d   = s_prdata_q;
    s_pready_d   = s_pready_q;
    s_pslverr_d  = s_pslverr_q;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          m_psel_d     = 1'b1;
          m_penable_d  = 1'b0;
          m_pwrite_d   = s_pwrite[pick_idx];
          m_paddr_d    = s_paddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_pwdata_d   = s_pwdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_d      = pick_oh;
          last_grant_d = pick_idx;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_penable_d = 1'b1;
        state_d     = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        // grant_q is the owner, so the response is steered without decoding an index.
        if (m_pready) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          s_prdata_d  = m_prdata;
          s_pready_d  = grant_q;
          s_pslverr_d = grant_q & {N_REQ{m_pslverr}};
          state_d     = ST_DONE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          s_prdata_d  = '0;
          s_pready_d  = grant_q;
          s_pslverr_d = grant_q;
          state_d     = ST_DONE;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_DONE: begin
        s_pready_d  = '0;
        s_pslverr_d = '0;
        grant_d     = '0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(N_REQ - 1);
      grant_q      <= '0;
      m_psel_q     <= 1'b0;
      m_penable_q  <= 1'b0;
      m_pwrite_q   <= 1'b0;
      m_paddr_q    <= '0;
      m_pwdata_q   <= '0;
      s_prdata_q   <= '0;
      s_pready_q   <= '0;
      s_pslverr_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      m_psel_q     <= m_psel_d;
      m_penable_q  <= m_penable_d;
      m_pwrite_q   <= m_pwrite_d;
      m_paddr_q    <= m_paddr_d;
      m_pwdata_q   <= m_pwdata_d;
      s_prdata_q   <= s_prdata_d;
      s_pready_q   <= s_pready_d;
      s_pslverr_q  <= s_pslverr_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign s_prdata  = s_prdata_q;
  assign s_pready  = s_pready_q;
  assign s_pslverr = s_pslverr_q;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: requester drivers plus a wait-state slave; expected transfers queued in grant order.
module tb_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    s_psel, s_penable, s_pwrite;
  logic [N*AW-1:0] s_paddr;
  logic [N*DW-1:0] s_pwdata;
  logic [DW-1:0]   s_prdata;
  logic [N-1:0]    s_pready, s_pslverr, grant;
  logic            m_psel, m_penable, m_pwrite;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata, m_prdata;
  logic            m_pready, m_pslverr;

  apb_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant(grant)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [1:0]    idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic [7:0]    wt;
    logic          drop;
  } txn_t;

  txn_t          tx_mem [N][8];
  int            tx_cnt [N];
  int            tx_head[N];
  txn_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            model_last = N - 1;
  logic [DW-1:0] last_rdata = '0;
  int            acc_cnt = 0;
  int            last_len = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input logic [1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic timed_out(input txn_t t);
`ifdef APB_ARB_TIMEOUT_EN
    return (int'(t.wt) + 1) > TO;
`else
    return (t.wt != t.wt);
`endif
  endfunction

  task automatic add_txn(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input logic er, input int wt, input logic dr);
    txn_t t;
    t.idx = 2'(i); t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.err = er; t.wt = 8'(wt); t.drop = dr;
    tx_mem[i][tx_cnt[i]] = t;
    tx_cnt[i]++;
  endtask

  task automatic drive_req(input int i);
    txn_t t;
    t = tx_mem[i][tx_head[i]];
    s_psel[i]              = 1'b1;
    s_penable[i]           = 1'b0;
    s_pwrite[i]            = t.wr;
    s_paddr[i*AW +: AW]    = t.addr;
    s_pwdata[i*DW +: DW]   = t.wdata;
  endtask

  task automatic run_phase(input int budget);
    int   rem[N];
    int   p, total, cyc;
    txn_t e;
    logic to;
    total = 0;
    for (int i = 0; i < N; i++) begin
      tx_head[i] = 0;
      rem[i]     = tx_cnt[i];
      total     += tx_cnt[i];
      if (tx_cnt[i] > 0) drive_req(i);
    end
    p = model_last;
    for (int n = 0; n < total; n++) begin
      logic fnd;
      fnd = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (p + k) % N;
        if (!fnd && rem[c] > 0) begin
          fnd = 1'b1;
          sb.push_back(tx_mem[c][tx_cnt[c] - rem[c]]);
          rem[c]--;
          p = c;
        end
      end
    end
    model_last = p;
    acc_cnt = 0;
    cyc = 0;
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge PCLK);
      cyc++;
      if (m_psel && m_penable) acc_cnt++;
      else begin
        if (acc_cnt != 0) last_len = acc_cnt;
        acc_cnt = 0;
      end
      if (m_psel && m_penable && sb.size() != 0) begin
        chk_eq("m_paddr", 64'(m_paddr), 64'(sb[0].addr));
        chk_eq("m_pwdata", 64'(m_pwdata), 64'(sb[0].wdata));
        chk_eq("m_pwrite", 64'(m_pwrite), 64'(sb[0].wr));
        chk_eq("grant_access", 64'(grant), 64'(oh(sb[0].idx)));
        if (acc_cnt > int'(sb[0].wt)) begin
          m_pready = 1'b1; m_prdata = sb[0].rdata; m_pslverr = sb[0].err;
        end else begin
          m_pready = 1'b0; m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
        end
      end else begin
        m_pready = 1'($urandom_range(0, 1)); m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
      end
      if (m_psel && !m_penable && sb.size() != 0 && sb[0].drop) s_psel[sb[0].idx] = 1'b0;
      chk_eq("onehot", 64'({$onehot0(grant), $onehot0(s_pready), (s_pslverr & ~s_pready) == '0}), 64'(3'b111));
      if (s_pready != '0) begin
        e  = sb.pop_front();
        to = timed_out(e);
        chk_eq("s_pready", 64'(s_pready), 64'(oh(e.idx)));
        chk_eq("grant_done", 64'(grant), 64'(oh(e.idx)));
        chk_eq("s_pslverr", 64'(s_pslverr), (to || e.err) ? 64'(oh(e.idx)) : 64'(0));
        chk_eq("s_prdata", 64'(s_prdata), to ? 64'(0) : 64'(e.rdata));
        chk_eq("m_psel_drop", 64'({m_psel, m_penable}), 64'(0));
        chk_eq("access_len", 64'(last_len), to ? 64'(TO) : 64'(int'(e.wt) + 1));
        last_rdata = to ? '0 : e.rdata;
        tx_head[e.idx]++;
        if (tx_head[e.idx] < tx_cnt[e.idx]) drive_req(int'(e.idx));
        else s_psel[e.idx] = 1'b0;
      end else begin
        chk_eq("s_prdata_hold", 64'(s_prdata), 64'(last_rdata));
      end
    end
    if (sb.size() != 0) begin
      chk_eq("phase_done", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    s_psel = '0; m_pready = 1'b0;
    for (int i = 0; i < N; i++) tx_cnt[i] = 0;
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    PRESET = 1'b1;
    s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0; s_pwdata = '0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
    for (int i = 0; i < N; i++) tx_cnt[i] = 0;
    #1;
    chk_eq("reset_ctrl", 64'({m_psel, m_penable, m_pwrite, grant, s_pready, s_pslverr}), 64'(0));
    chk_eq("reset_data", 64'({m_paddr, s_prdata}), 64'(0));
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;

    // Single write, slave ready tied high: latency check cycle by cycle.
    @(negedge PCLK);
    s_psel[0] = 1'b1; s_pwrite[0] = 1'b1; s_paddr[0 +: AW] = 13'h010; s_pwdata[0 +: DW] = 32'hDEADBEEF;
    m_pready = 1'b1; m_prdata = 32'hCAFE0001; m_pslverr = 1'b0;
    @(negedge PCLK);
    chk_eq("t1_setup", 64'({m_psel, m_penable, m_pwrite, grant, s_pready}), 64'({3'b101, 4'b0001, 4'b0000}));
    chk_eq("t1_paddr", 64'(m_paddr), 64'(13'h010));
    chk_eq("t1_pwdata", 64'(m_pwdata), 64'(32'hDEADBEEF));
    @(negedge PCLK);
    chk_eq("t1_access", 64'({m_psel, m_penable, s_pready}), 64'({2'b11, 4'b0000}));
    @(negedge PCLK);
    chk_eq("t1_pready", 64'({s_pready, s_pslverr, m_psel}), 64'({4'b0001, 4'b0000, 1'b0}));
    chk_eq("t1_prdata", 64'(s_prdata), 64'(32'hCAFE0001));
    s_psel = '0;
    @(negedge PCLK);
    chk_eq("t1_done", 64'({s_pready, grant}), 64'(0));
    m_pready = 1'b0;
    model_last = 0;
    last_rdata = 32'hCAFE0001;
    @(negedge PCLK);

    // All four requesting back-to-back: pure rotation.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add_txn(i, 1'((i + r) & 1), AW'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);
    run_phase(400);

    // Requester 2 read with 5 wait states and a slave error.
    add_txn(2, 1'b0, 13'h1F4, $urandom, 32'h12345678, 1'b1, 5, 1'b0);
    run_phase(100);

    // Uneven load, mixed waits, requesters abandoning PSEL mid-transfer.
    add_txn(0, 1'b1, AW'($urandom), $urandom, $urandom, 1'b0, 2, 1'b0);
    add_txn(0, 1'b0, AW'($urandom), $urandom, $urandom, 1'b1, 0, 1'b0);
    add_txn(0, 1'b1, AW'($urandom), $urandom, $urandom, 1'b0, 7, 1'b0);
    add_txn(1, 1'b0, AW'($urandom), $urandom, $urandom, 1'b0, 3, 1'b1);
    add_txn(3, 1'b1, AW'($urandom), $urandom, $urandom, 1'b1, 0, 1'b1);
    add_txn(3, 1'b0, AW'($urandom), $urandom, $urandom, 1'b0, 1, 1'b0);
    run_phase(400);

    // Reset while in ACCESS.
    s_psel[2] = 1'b1; s_pwrite[2] = 1'b0; s_paddr[2*AW +: AW] = 13'h0AA; m_pready = 1'b0;
    k = 0;
    while (!m_penable && k < 20) begin
      @(negedge PCLK);
      m_pready = 1'b0;
      k++;
    end
    chk_eq("t4_reach_access", 64'(m_penable), 64'(1));
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk_eq("t4_async_reset", 64'({m_psel, m_penable, grant, s_pready}), 64'(0));
    s_psel = '0;
    @(negedge PCLK);
    PRESET = 1'b0;
    model_last = N - 1;
    last_rdata = '0;
    add_txn(1, 1'b1, 13'h123, 32'hA5A5_0F0F, $urandom, 1'b0, 1, 1'b0);
    run_phase(100);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: watchdog aborts, next request is served normally.
    add_txn(3, 1'b0, 13'h0F0, $urandom, $urandom, 1'b0, 60, 1'b0);
    add_txn(0, 1'b0, 13'h00F, $urandom, 32'h0BADF00D, 1'b0, 0, 1'b0);
    run_phase(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
